// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, reset PC
// and the {instr, pc} record carried from memory response to IF_ID.
package instr_fetch_unit_pkg;

    localparam int IFU_ADDR_W  = 12;
    localparam int IFU_INSTR_W = 19;
    localparam int IFU_DEPTH   = 2;

    localparam logic [IFU_ADDR_W-1:0] PC_RESET = '0;

    typedef struct packed {
        logic [IFU_INSTR_W-1:0] instr;
        logic [IFU_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction-memory read port, ID-stage
// redirect and the valid/ready handshake into IF_ID.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = IFU_ADDR_W,
    parameter int INSTR_W = IFU_INSTR_W
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; head is read combinationally.
// Storage is not reset -- only pointers and count are.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 31,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-cycle-latency reads to instruction
// memory and queues {instr, pc} for IF_ID; a redirect flushes and restarts.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = IFU_ADDR_W,
    parameter int INSTR_W = IFU_INSTR_W,
    parameter int DEPTH   = IFU_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int EW    = INSTR_W + ADDR_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic [CNT_W-1:0]  count;
    logic [EW-1:0]     head;
    logic              empty;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occ;

    // Occupancy counts the outstanding read so a response always has a slot.
    assign occ   = OCC_W'(count) + OCC_W'(vld_p1) - OCC_W'(pop);
    assign issue = ~reset & ~bus.redirect & (occ < DEPTH_OCC);
    assign push  = vld_p1 & ~bus.redirect;
    assign pop   = bus.out_valid & bus.out_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = ~empty & ~bus.redirect;
    assign bus.out_instr = empty ? '0 : head[EW-1:ADDR_W];
    assign bus.out_pc    = empty ? '0 : head[ADDR_W-1:0];

    // p0 -> p1: request issued, response due next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= ADDR_W'(PC_RESET);
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (bus.redirect)  fetch_pc <= bus.redirect_pc;
            else if (issue)    fetch_pc <= fetch_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= fetch_pc;
    end

    // p1 -> queue: memory word paired with the address it was read from
    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (push),
        .push_data ({bus.imem_rdata, pc_p1}),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .empty     (empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Cycle table for handshake/request timing plus a scoreboard of the expected
// instruction stream, restarted on every reset or redirect.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int AW = 12;
    localparam int IW = 19;
    localparam int NV = 33;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory holds mem[i] = i; idle cycles return all-ones so stale data shows up.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? IW'(bus.imem_addr) : '1;
    end

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          rdr;
        logic [AW-1:0] rpc;
        logic          ev;
        logic          cp;
        logic [AW-1:0] epc;
        logic          er;
        logic [AW-1:0] ea;
    } vec_t;

    vec_t         tbl [NV];
    fetch_entry_t exp_q [$];
    fetch_entry_t sb_e;
    int total = 0;
    int bad = 0;
    int accepts = 0;
    int exp_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic restart_sb(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            p = start + AW'(k);
            exp_q.push_back('{instr: IW'(p), pc: p});
        end
    endtask

    function automatic vec_t v(input logic rst, input logic rdy, input logic rdr,
                               input logic [AW-1:0] rpc, input logic ev, input logic cp,
                               input logic [AW-1:0] epc, input logic er,
                               input logic [AW-1:0] ea);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rdr = rdr; r.rpc = rpc;
        r.ev = ev; r.cp = cp; r.epc = epc; r.er = er; r.ea = ea;
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid && bus.out_ready && !bus.redirect) begin
            accepts++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc %0h want none", bus.out_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.out_pc), 32'(sb_e.pc));
                chk("sb_instr", 32'(bus.out_instr), 32'(sb_e.instr));
            end
        end
    end

    initial begin
        //            rst  rdy  rdr  rpc      ev   cp   epc      er   ea
        tbl[0]  = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h000);
        tbl[1]  = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h001);
        tbl[2]  = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h000,1'b1,12'h002);
        tbl[3]  = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h001,1'b0,12'h003);
        tbl[4]  = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h001,1'b0,12'h003);
        tbl[5]  = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h001,1'b0,12'h003);
        tbl[6]  = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h001,1'b0,12'h003);
        tbl[7]  = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h001,1'b0,12'h003);
        tbl[8]  = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h001,1'b1,12'h003);
        tbl[9]  = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h002,1'b1,12'h004);
        tbl[10] = v(1'b0,1'b1,1'b1,12'h040,1'b0,1'b0,12'h000,1'b0,12'h005);
        tbl[11] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h040);
        tbl[12] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h041);
        tbl[13] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h040,1'b1,12'h042);
        tbl[14] = v(1'b0,1'b1,1'b1,12'hFFE,1'b0,1'b0,12'h000,1'b0,12'h043);
        tbl[15] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'hFFE);
        tbl[16] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'hFFF);
        tbl[17] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'hFFE,1'b1,12'h000);
        tbl[18] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'hFFF,1'b1,12'h001);
        tbl[19] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h000,1'b1,12'h002);
        tbl[20] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h001,1'b1,12'h003);
        tbl[21] = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h002,1'b0,12'h004);
        tbl[22] = v(1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,12'h002,1'b0,12'h004);
        tbl[23] = v(1'b0,1'b0,1'b1,12'h100,1'b0,1'b0,12'h000,1'b0,12'h004);
        tbl[24] = v(1'b0,1'b0,1'b1,12'h200,1'b0,1'b0,12'h000,1'b0,12'h100);
        tbl[25] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h200);
        tbl[26] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h201);
        tbl[27] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h200,1'b1,12'h202);
        tbl[28] = v(1'b1,1'b0,1'b0,12'h000,1'b0,1'b0,12'h000,1'b0,12'h000);
        tbl[29] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h000);
        tbl[30] = v(1'b0,1'b1,1'b0,12'h000,1'b0,1'b1,12'h000,1'b1,12'h001);
        tbl[31] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h000,1'b1,12'h002);
        tbl[32] = v(1'b0,1'b1,1'b0,12'h000,1'b1,1'b1,12'h001,1'b1,12'h003);

        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        restart_sb('0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            reset           = tbl[i].rst;
            bus.out_ready   = tbl[i].rdy;
            bus.redirect    = tbl[i].rdr;
            bus.redirect_pc = tbl[i].rpc;
            if (tbl[i].rst)      restart_sb('0);
            else if (tbl[i].rdr) restart_sb(tbl[i].rpc);
            if (tbl[i].ev && tbl[i].rdy && !tbl[i].rdr && !tbl[i].rst) exp_acc++;
            @(negedge clk);
            chk($sformatf("c%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].er));
            if (!tbl[i].rst) begin
                chk($sformatf("c%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
                chk($sformatf("c%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].ea));
                if (tbl[i].cp)
                    chk($sformatf("c%0d_pc", i), 32'(bus.out_pc), 32'(tbl[i].epc));
            end
        end

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("accept_count", 32'(accepts), 32'(exp_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
